// File: rtl/knight_anim_addr_gen.sv
// Knight sprite-sheet address generator: raster position -> ROM address, animation frame sequencing, and sprite hit.
// Latency is 1 vga_clk from DrawX/DrawY/blank to the outputs; there is no backpressure because the module is raster-paced.
module knight_anim_addr_gen #(
    parameter int SPR_W    = 30,
    parameter int SPR_H    = 64,
    parameter int N_FRAMES = 4,
    parameter int HOLD     = 6,
    parameter int ADDR_W   = 13,
    localparam int FW      = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              anim_en,
    input  logic              anim_restart,
    input  logic              facing_left,
    input  logic [9:0]        knight_x,
    input  logic [9:0]        knight_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_hit,
    output logic              blank_d,
    output logic [FW-1:0]     frame_idx,
    output logic              anim_wrap
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              wrap_q, wrap_d;
    logic [9:0]        shx_q, shy_q;
    logic              shfl_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hit_q, hit_d;
    logic              blank_q;

    logic [10:0]       dx, dy;
    logic [9:0]        col;

    always_comb begin
        state_d = anim_en ? RUN : IDLE;
        frame_d = frame_q;
        hold_d  = hold_q;
        wrap_d  = 1'b0;
        if (anim_restart) begin
            frame_d = '0;
            hold_d  = '0;
        end else if (state_q == RUN && frame_start) begin
            if (hold_q == HW'(HOLD - 1)) begin
                hold_d = '0;
                if (frame_q == FW'(N_FRAMES - 1)) begin
                    frame_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    // Both operands are zero-extended, so bit 10 of the difference marks a raster position left of/above the sprite.
    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, shx_q};
        dy     = {1'b0, DrawY} - {1'b0, shy_q};
        col    = shfl_q ? (10'(SPR_W - 1) - dx[9:0]) : dx[9:0];
        hit_d  = ~dx[10] && (dx[9:0] < 10'(SPR_W)) && ~dy[10] && (dy[9:0] < 10'(SPR_H));
        addr_d = '0;
        if (hit_d) begin
            addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(dy[9:0]) * ADDR_W'(SPR_W)
                   + ADDR_W'(col);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            hold_q  <= '0;
            wrap_q  <= 1'b0;
            shx_q   <= '0;
            shy_q   <= '0;
            shfl_q  <= 1'b0;
            addr_q  <= '0;
            hit_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            wrap_q  <= wrap_d;
            addr_q  <= addr_d;
            hit_q   <= hit_d;
            blank_q <= blank;
            // Position and facing only change at frame boundaries so a frame never tears.
            if (frame_start) begin
                shx_q  <= knight_x;
                shy_q  <= knight_y;
                shfl_q <= facing_left;
            end
        end
    end

    assign rom_address = addr_q;
    assign sprite_hit  = hit_q;
    assign blank_d     = blank_q;
    assign frame_idx   = frame_q;
    assign anim_wrap   = wrap_q;

endmodule

// File: tb/tb_knight_anim_addr_gen.sv
// Bench for knight_anim_addr_gen: directed vector table, multi-cycle corner sequences, then randomized run against a reference model.
module tb_knight_anim_addr_gen;

    localparam int SPR_W    = 30;
    localparam int SPR_H    = 64;
    localparam int N_FRAMES = 4;
    localparam int HOLD     = 6;
    localparam int ADDR_W   = 13;

    logic              vga_clk = 1'b0;
    logic              reset, frame_start, anim_en, anim_restart, facing_left, blank;
    logic [9:0]        knight_x, knight_y, DrawX, DrawY;
    logic [ADDR_W-1:0] rom_address;
    logic              sprite_hit, blank_d, anim_wrap;
    logic [1:0]        frame_idx;

    int checks   = 0;
    int failures = 0;

    // Reference model: animation position is a count of advancing pulses since the last restart.
    int m_shx, m_shy, m_fl, m_pulses, m_wrap;
    int e_addr, e_hit, e_blank;

    typedef struct {
        int x;
        int y;
        int addr;
        int hit;
    } vec_t;
    vec_t vt[9];

    knight_anim_addr_gen #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(N_FRAMES), .HOLD(HOLD), .ADDR_W(ADDR_W)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start), .anim_en(anim_en),
        .anim_restart(anim_restart), .facing_left(facing_left), .knight_x(knight_x),
        .knight_y(knight_y), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .rom_address(rom_address), .sprite_hit(sprite_hit), .blank_d(blank_d),
        .frame_idx(frame_idx), .anim_wrap(anim_wrap)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int dx, dy;
        if (reset) begin
            m_shx = 0; m_shy = 0; m_fl = 0; m_pulses = 0; m_wrap = 0;
            e_addr = 0; e_hit = 0; e_blank = 0;
        end else begin
            dx      = int'(DrawX) - m_shx;
            dy      = int'(DrawY) - m_shy;
            e_hit   = (dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H) ? 1 : 0;
            e_addr  = e_hit ? (m_pulses / HOLD) * SPR_W * SPR_H + dy * SPR_W
                              + (m_fl ? SPR_W - 1 - dx : dx) : 0;
            e_blank = int'(blank);
            m_wrap  = 0;
            if (anim_restart) begin
                m_pulses = 0;
            end else if (frame_start && anim_en) begin
                m_pulses++;
                if (m_pulses == HOLD * N_FRAMES) begin
                    m_pulses = 0;
                    m_wrap   = 1;
                end
            end
            if (frame_start) begin
                m_shx = int'(knight_x);
                m_shy = int'(knight_y);
                m_fl  = int'(facing_left);
            end
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        model_step();
        #1;
    endtask

    task automatic pulse_gap();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic run_vec(input int i);
        DrawX = 10'(vt[i].x);
        DrawY = 10'(vt[i].y);
        tick();
        check($sformatf("vec%0d_addr", i), int'(rom_address), vt[i].addr);
        check($sformatf("vec%0d_hit", i), int'(sprite_hit), vt[i].hit);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, int'(rom_address), 0);
        check({tag, "_hit"}, int'(sprite_hit), 0);
        check({tag, "_blank_d"}, int'(blank_d), 0);
        check({tag, "_frame"}, int'(frame_idx), 0);
        check({tag, "_wrap"}, int'(anim_wrap), 0);
    endtask

    task automatic check_model(input int cyc);
        check($sformatf("rnd%0d_addr", cyc), int'(rom_address), e_addr);
        check($sformatf("rnd%0d_hit", cyc), int'(sprite_hit), e_hit);
        check($sformatf("rnd%0d_blank_d", cyc), int'(blank_d), e_blank);
        check($sformatf("rnd%0d_frame", cyc), int'(frame_idx), m_pulses / HOLD);
        check($sformatf("rnd%0d_wrap", cyc), int'(anim_wrap), m_wrap);
    endtask

    initial begin
        int wraps;
        int prev_reset;
        // Knight at (100,200), facing right, frame 0
        vt[0] = '{100, 200,    0, 1};
        vt[1] = '{129, 263, 1919, 1};
        vt[2] = '{130, 263,    0, 0};
        vt[3] = '{ 99, 200,    0, 0};
        vt[4] = '{100, 263, 1890, 1};
        vt[5] = '{100, 264,    0, 0};
        // Same position, mirrored
        vt[6] = '{100, 200,   29, 1};
        vt[7] = '{129, 200,    0, 1};
        vt[8] = '{129, 263, 1890, 1};

        reset = 1'b1; frame_start = 1'b0; anim_en = 1'b0; anim_restart = 1'b0;
        facing_left = 1'b0; blank = 1'b1; knight_x = '0; knight_y = '0;
        DrawX = 10'd5; DrawY = 10'd5;
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;

        knight_x = 10'd100; knight_y = 10'd200;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 6; i++) run_vec(i);
        check("blank_d_follow", int'(blank_d), 1);

        facing_left = 1'b1;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 6; i < 9; i++) run_vec(i);

        facing_left = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        anim_en = 1'b1; tick();
        repeat (6) pulse_gap();
        check("frame_after_6", int'(frame_idx), 1);
        DrawX = 10'd100; DrawY = 10'd200; tick();
        check("addr_frame1", int'(rom_address), 1920);

        wraps = 0;
        for (int p = 0; p < 18; p++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            wraps += int'(anim_wrap);
            if (p == 17) check("wrap_on_24th", int'(anim_wrap), 1);
            tick();
            wraps += int'(anim_wrap);
        end
        check("wrap_count", wraps, 1);
        check("frame_after_24", int'(frame_idx), 0);

        anim_en = 1'b0; tick();
        knight_x = 10'd300; tick();
        DrawX = 10'd100; DrawY = 10'd200; tick();
        check("shadow_hold_hit", int'(sprite_hit), 1);
        check("shadow_hold_addr", int'(rom_address), 0);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        DrawX = 10'd300; tick();
        check("shadow_load_hit", int'(sprite_hit), 1);

        anim_en = 1'b1; tick();
        repeat (17) pulse_gap();
        check("frame_before_restart", int'(frame_idx), 2);
        knight_x = 10'd400;
        frame_start = 1'b1; anim_restart = 1'b1; tick();
        frame_start = 1'b0; anim_restart = 1'b0;
        check("restart_frame", int'(frame_idx), 0);
        check("restart_wrap", int'(anim_wrap), 0);
        DrawX = 10'd400; DrawY = 10'd200; tick();
        check("restart_shadow_hit", int'(sprite_hit), 1);
        repeat (5) pulse_gap();
        check("restart_hold_cleared", int'(frame_idx), 0);
        pulse_gap();
        check("restart_then_6", int'(frame_idx), 1);
        repeat (12) pulse_gap();
        check("frame3", int'(frame_idx), 3);
        check("frame3_addr", int'(rom_address), 3 * 1920);

        reset = 1'b1; tick(); reset = 1'b0;
        check_all_zero("midline_reset");
        anim_en = 1'b0; tick();
        knight_x = 10'd630; knight_y = 10'd450;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        DrawX = 10'd639; DrawY = 10'd479; tick();
        check("corner_addr", int'(rom_address), 879);
        check("corner_hit", int'(sprite_hit), 1);

        prev_reset = 0;
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 499) == 0);
            frame_start  = (prev_reset == 0) && ($urandom_range(0, 7) == 0);
            if (!frame_start && $urandom_range(0, 49) == 0) anim_en = ~anim_en;
            anim_restart = ($urandom_range(0, 59) == 0);
            facing_left  = 1'($urandom_range(0, 1));
            blank        = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                knight_x = 10'($urandom_range(0, 639));
                knight_y = 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 1) == 0) begin
                DrawX = 10'($urandom_range(0, 639));
                DrawY = 10'($urandom_range(0, 479));
            end else begin
                DrawX = 10'((m_shx + $urandom_range(0, 36) > 645) ? 639 : m_shx + $urandom_range(0, 36) - 3 + 3 * (m_shx < 3));
                DrawY = 10'((m_shy + $urandom_range(0, 70) > 485) ? 479 : m_shy + $urandom_range(0, 70) - 3 + 3 * (m_shy < 3));
            end
            prev_reset = int'(reset);
            tick();
            check_model(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
